// File: rtl/mem_ls_unit_if.sv
// Data-bus bundle between the MEM-stage load/store unit (master) and memory (slave).
// Request/acknowledge handshake with big-endian byte-lane selects.
interface mem_ls_unit_if;
  localparam int unsigned REG_W = 32;

  logic [REG_W-1:0] bus_addr_o;
  logic [REG_W-1:0] bus_wdata_o;
  logic [3:0]       bus_sel_o;
  logic             bus_we_o;
  logic             bus_req_o;
  logic             bus_ack_i;
  logic [REG_W-1:0] bus_rdata_i;

  modport master (
    output bus_addr_o, bus_wdata_o, bus_sel_o, bus_we_o, bus_req_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_addr_o, bus_wdata_o, bus_sel_o, bus_we_o, bus_req_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_ls_unit.sv
// MIPS MEM stage with a wait-stated request/ack data bus, byte/halfword formatting,
// alignment exceptions and a bus timeout; stalls the pipeline while an access is in flight.
module mem_ls_unit #(
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  parameter  int unsigned CNT_WIDTH      = 8,
  localparam int unsigned REG_ADDR_W     = 5,
  localparam int unsigned REG_W          = 32,
  localparam int unsigned ALUOP_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic [REG_W-1:0]      hi_i,
  input  logic [REG_W-1:0]      lo_i,
  input  logic                  whilo_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [REG_W-1:0]      mem_addr_i,
  input  logic [REG_W-1:0]      reg2_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic                  whilo_o,
  mem_ls_unit_if.master         bus,
  output logic                  stallreq_o,
  output logic                  adel_o,
  output logic                  ades_o,
  output logic                  bus_err_o
);

  localparam logic [ALUOP_W-1:0] OP_LB  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] OP_LBU = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] OP_LH  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] OP_LHU = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] OP_LW  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] OP_SB  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] OP_SH  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] OP_SW  = 8'b1110_1011;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0]     ldata_q, ldata_d;
  logic [REG_W-1:0]     bus_addr_q, bus_addr_d;
  logic [REG_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]           bus_sel_q, bus_sel_d;
  logic                 bus_we_q, bus_we_d;
  logic                 bus_req_q, bus_req_d;
  logic                 err_q, err_d;

  logic             is_byte_c, is_half_c, is_word_c;
  logic             is_load_c, is_store_c, is_mem_c;
  logic             misalign_c, mem_go_c, stall_c;
  logic [3:0]       sel_c;
  logic [REG_W-1:0] st_data_c;
  logic [7:0]       lbyte_c;
  logic [15:0]      lhalf_c;
  logic [REG_W-1:0] load_fmt_c;
  logic             wreg_c;
  logic [REG_W-1:0] wdata_c;

  // Opcode decode and alignment check
  always_comb begin
    is_byte_c  = (aluop_i == OP_LB) || (aluop_i == OP_LBU) || (aluop_i == OP_SB);
    is_half_c  = (aluop_i == OP_LH) || (aluop_i == OP_LHU) || (aluop_i == OP_SH);
    is_word_c  = (aluop_i == OP_LW) || (aluop_i == OP_SW);
    is_store_c = (aluop_i == OP_SB) || (aluop_i == OP_SH) || (aluop_i == OP_SW);
    is_load_c  = (is_byte_c || is_half_c || is_word_c) && !is_store_c;
    is_mem_c   = is_load_c || is_store_c;
    misalign_c = (is_half_c && mem_addr_i[0]) ||
                 (is_word_c && (mem_addr_i[1:0] != 2'b00));
    mem_go_c   = is_mem_c && !misalign_c;
  end

  // Big-endian lane select and store-data replication
  always_comb begin
    sel_c     = 4'b1111;
    st_data_c = '0;
    if (is_byte_c) begin
      sel_c = 4'b1000 >> mem_addr_i[1:0];
    end else if (is_half_c) begin
      sel_c = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end
    if (aluop_i == OP_SB) begin
      st_data_c = {4{reg2_i[7:0]}};
    end else if (aluop_i == OP_SH) begin
      st_data_c = {2{reg2_i[15:0]}};
    end else if (aluop_i == OP_SW) begin
      st_data_c = reg2_i;
    end
  end

  // Load formatting from the captured bus word
  always_comb begin
    lbyte_c = 8'h00;
    case (mem_addr_i[1:0])
      2'b00:   lbyte_c = ldata_q[31:24];
      2'b01:   lbyte_c = ldata_q[23:16];
      2'b10:   lbyte_c = ldata_q[15:8];
      default: lbyte_c = ldata_q[7:0];
    endcase
    lhalf_c = mem_addr_i[1] ? ldata_q[15:0] : ldata_q[31:16];
    case (aluop_i)
      OP_LB:   load_fmt_c = {{24{lbyte_c[7]}}, lbyte_c};
      OP_LBU:  load_fmt_c = {24'h000000, lbyte_c};
      OP_LH:   load_fmt_c = {{16{lhalf_c[15]}}, lhalf_c};
      OP_LHU:  load_fmt_c = {16'h0000, lhalf_c};
      default: load_fmt_c = ldata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ldata_q     <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      bus_we_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ldata_q     <= ldata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      bus_we_q    <= bus_we_d;
      bus_req_q   <= bus_req_d;
      err_q       <= err_d;
    end
  end

  // Bus access sequencing; DONE always returns to IDLE so an op is issued once
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ldata_d     = ldata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    bus_we_d    = bus_we_q;
    bus_req_d   = bus_req_q;
    err_d       = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_go_c) begin
          stall_c     = 1'b1;
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store_c;
          bus_addr_d  = {mem_addr_i[REG_W-1:2], 2'b00};
          bus_sel_d   = sel_c;
          bus_wdata_d = st_data_c;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (bus.bus_ack_i) begin
          ldata_d   = bus.bus_rdata_i;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES))) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-back selection; memory ops only write back once their access completes
  always_comb begin
    wreg_c  = wreg_i;
    wdata_c = wdata_i;
    if (is_mem_c) begin
      wreg_c = 1'b0;
      if (state_q == DONE) begin
        wreg_c = wreg_i && !err_q;
        if (is_load_c) begin
          wdata_c = load_fmt_c;
        end
      end
    end
  end

  always_comb begin
    wd_o       = rst ? NOP_REG_ADDR : wd_i;
    wreg_o     = !rst && wreg_c;
    wdata_o    = rst ? '0 : wdata_c;
    hi_o       = rst ? '0 : hi_i;
    lo_o       = rst ? '0 : lo_i;
    whilo_o    = !rst && whilo_i;
    stallreq_o = !rst && stall_c;
    adel_o     = !rst && is_load_c && misalign_c;
    ades_o     = !rst && is_store_c && misalign_c;
    bus_err_o  = !rst && err_q;
  end

  assign bus.bus_addr_o  = bus_addr_q;
  assign bus.bus_wdata_o = bus_wdata_q;
  assign bus.bus_sel_o   = bus_sel_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_req_o   = bus_req_q;

endmodule

// File: tb/tb_mem_ls_unit.sv
// Directed bench for mem_ls_unit: vector table for single-cycle behaviour,
// hand-written bus sequences for wait states, timeout and reset mid-access.
module tb_mem_ls_unit;

  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        stallreq_o;
  logic        adel_o;
  logic        ades_o;
  logic        bus_err_o;

  int n_tests;
  int n_fail;

  mem_ls_unit_if bus_if();

  mem_ls_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wd_i      (wd_i),
    .wreg_i    (wreg_i),
    .wdata_i   (wdata_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .whilo_i   (whilo_i),
    .aluop_i   (aluop_i),
    .mem_addr_i(mem_addr_i),
    .reg2_i    (reg2_i),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o),
    .wdata_o   (wdata_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .whilo_o   (whilo_o),
    .bus       (bus_if),
    .stallreq_o(stallreq_o),
    .adel_o    (adel_o),
    .ades_o    (ades_o),
    .bus_err_o (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic        wreg;
    logic [31:0] wdata;
    logic        ack;
    logic        e_adel;
    logic        e_ades;
    logic        e_wreg;
    logic        chk_wd;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  // One full memory access: IDLE issue, BUSY with n_wait ack-less cycles, DONE checks
  task automatic do_access(input string nm, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] r2, input logic wr, input logic [31:0] rdata,
                           input int n_wait, input int e_stalls, input logic [31:0] e_addr,
                           input logic [3:0] e_sel, input logic [31:0] e_bwd, input logic e_we,
                           input logic e_wreg, input logic chk_wd, input logic [31:0] e_wd,
                           input logic e_err);
    int  stalls;
    int  k;
    bit  done;
    @(negedge clk);
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = r2;
    wreg_i     = wr;
    wdata_i    = 32'h0BAD_0BAD;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = 32'h5A5A_5A5A;
    #1;
    chk({nm, " idle stall"}, 32'(stallreq_o), 32'd1);
    chk({nm, " idle req"}, 32'(bus_if.bus_req_o), 32'd0);
    stalls = 1;
    k      = 0;
    done   = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      bus_if.bus_ack_i   = (k == n_wait);
      bus_if.bus_rdata_i = (k == n_wait) ? rdata : 32'h5A5A_5A5A;
      #1;
      if (stallreq_o) begin
        stalls++;
        chk({nm, " busy req"}, 32'(bus_if.bus_req_o), 32'd1);
        if (k == 0) begin
          chk({nm, " addr"}, bus_if.bus_addr_o, e_addr);
          chk({nm, " sel"}, 32'(bus_if.bus_sel_o), 32'(e_sel));
          chk({nm, " bus wdata"}, bus_if.bus_wdata_o, e_bwd);
          chk({nm, " we"}, 32'(bus_if.bus_we_o), 32'(e_we));
        end
        k++;
      end else begin
        done = 1'b1;
        bus_if.bus_ack_i = 1'b0;
        chk({nm, " stall cycles"}, 32'(stalls), 32'(e_stalls));
        chk({nm, " done req"}, 32'(bus_if.bus_req_o), 32'd0);
        chk({nm, " wreg"}, 32'(wreg_o), 32'(e_wreg));
        chk({nm, " bus_err"}, 32'(bus_err_o), 32'(e_err));
        if (chk_wd) chk({nm, " wdata"}, wdata_o, e_wd);
        #1;
        aluop_i = OP_OR;
        wreg_i  = 1'b0;
      end
    end
    chk({nm, " reached done"}, 32'(done), 32'd1);
    @(negedge clk);
    #1;
    chk({nm, " after bus_err"}, 32'(bus_err_o), 32'd0);
    chk({nm, " after stall"}, 32'(stallreq_o), 32'd0);
    chk({nm, " after req"}, 32'(bus_if.bus_req_o), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst        = 1'b1;
    wd_i       = 5'd7;
    wreg_i     = 1'b1;
    wdata_i    = 32'h1111_2222;
    hi_i       = 32'hAAAA_0001;
    lo_i       = 32'hBBBB_0002;
    whilo_i    = 1'b1;
    aluop_i    = OP_LW;
    mem_addr_i = 32'h0000_0102;
    reg2_i     = 32'h0;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = 32'h0;

    vecs[0] = '{OP_OR, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{OP_OR, 32'h0000_0000, 1'b0, 32'h8765_4321, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{OP_LH, 32'h0000_0101, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{OP_LHU, 32'h0000_0103, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{OP_LW, 32'h0000_0102, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_SW, 32'h0000_0102, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{OP_SH, 32'h0000_0201, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Outputs while reset is held
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst wd_o", 32'(wd_o), 32'd0);
    chk("rst wreg_o", 32'(wreg_o), 32'd0);
    chk("rst hi_o", hi_o, 32'd0);
    chk("rst whilo_o", 32'(whilo_o), 32'd0);
    chk("rst stall", 32'(stallreq_o), 32'd0);
    chk("rst adel", 32'(adel_o), 32'd0);
    chk("rst req", 32'(bus_if.bus_req_o), 32'd0);
    chk("rst sel", 32'(bus_if.bus_sel_o), 32'd0);
    aluop_i = OP_OR;
    rst     = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      aluop_i    = vecs[i].op;
      mem_addr_i = vecs[i].addr;
      wreg_i     = vecs[i].wreg;
      wdata_i    = vecs[i].wdata;
      reg2_i     = 32'hCAFE_F00D;
      wd_i       = 5'(i + 3);
      hi_i       = 32'h1000_0000 + 32'(i);
      lo_i       = 32'h2000_0000 + 32'(i);
      whilo_i    = i[0];
      bus_if.bus_ack_i = vecs[i].ack;
      #1;
      chk($sformatf("v%0d adel", i), 32'(adel_o), 32'(vecs[i].e_adel));
      chk($sformatf("v%0d ades", i), 32'(ades_o), 32'(vecs[i].e_ades));
      chk($sformatf("v%0d wreg", i), 32'(wreg_o), 32'(vecs[i].e_wreg));
      chk($sformatf("v%0d stall", i), 32'(stallreq_o), 32'd0);
      chk($sformatf("v%0d wd_o", i), 32'(wd_o), 32'(i + 3));
      chk($sformatf("v%0d hi_o", i), hi_o, 32'h1000_0000 + 32'(i));
      chk($sformatf("v%0d lo_o", i), lo_o, 32'h2000_0000 + 32'(i));
      chk($sformatf("v%0d whilo", i), 32'(whilo_o), 32'(i % 2));
      if (vecs[i].chk_wd) chk($sformatf("v%0d wdata", i), wdata_o, vecs[i].wdata);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d no req", i), 32'(bus_if.bus_req_o), 32'd0);
    end
    bus_if.bus_ack_i = 1'b0;
    wd_i = 5'd9;

    do_access("LW", OP_LW, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 0, 2, 32'h100, 4'b1111,
              32'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_access("LB", OP_LB, 32'h103, 32'h0, 1'b1, 32'h1234_56F0, 0, 2, 32'h100, 4'b0001,
              32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0);
    do_access("LBU", OP_LBU, 32'h103, 32'h0, 1'b1, 32'h1234_56F0, 0, 2, 32'h100, 4'b0001,
              32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_00F0, 1'b0);
    do_access("LB+", OP_LB, 32'h001, 32'h0, 1'b1, 32'h127F_5678, 1, 3, 32'h000, 4'b0100,
              32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_007F, 1'b0);
    do_access("SH", OP_SH, 32'h202, 32'hAAAA_5678, 1'b0, 32'h0, 3, 5, 32'h200, 4'b0011,
              32'h5678_5678, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    do_access("LH", OP_LH, 32'h102, 32'h0, 1'b1, 32'h1234_8001, 2, 4, 32'h100, 4'b0011,
              32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001, 1'b0);
    do_access("LHU", OP_LHU, 32'h100, 32'h0, 1'b1, 32'h8001_1234, 0, 2, 32'h100, 4'b1100,
              32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_8001, 1'b0);
    do_access("SB", OP_SB, 32'h001, 32'h1234_56A5, 1'b0, 32'h0, 1, 3, 32'h000, 4'b0100,
              32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    do_access("SW", OP_SW, 32'h204, 32'hCAFE_BABE, 1'b0, 32'h0, 0, 2, 32'h204, 4'b1111,
              32'hCAFE_BABE, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    do_access("TMO", OP_LW, 32'h300, 32'h0, 1'b1, 32'h0, 1000, 6, 32'h300, 4'b1111,
              32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while an access is outstanding
    @(negedge clk);
    aluop_i    = OP_LW;
    mem_addr_i = 32'h400;
    wreg_i     = 1'b1;
    wd_i       = 5'd12;
    bus_if.bus_ack_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rstb busy req", 32'(bus_if.bus_req_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstb stall", 32'(stallreq_o), 32'd0);
    chk("rstb wd_o", 32'(wd_o), 32'd0);
    chk("rstb wreg", 32'(wreg_o), 32'd0);
    chk("rstb req held", 32'(bus_if.bus_req_o), 32'd1);
    @(negedge clk);
    #1;
    chk("rstb req drop", 32'(bus_if.bus_req_o), 32'd0);
    chk("rstb addr clr", bus_if.bus_addr_o, 32'd0);
    chk("rstb sel clr", 32'(bus_if.bus_sel_o), 32'd0);
    rst     = 1'b0;
    aluop_i = OP_OR;
    wreg_i  = 1'b0;
    @(negedge clk);
    #1;
    chk("rstb idle stall", 32'(stallreq_o), 32'd0);
    chk("rstb idle req", 32'(bus_if.bus_req_o), 32'd0);

    do_access("LW2", OP_LW, 32'h104, 32'h0, 1'b1, 32'h0123_4567, 0, 2, 32'h104, 4'b1111,
              32'h0, 1'b0, 1'b1, 1'b1, 32'h0123_4567, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
